sar_search: RTL and testbench
=============================

Name: sar_search

Overview:
- Bit-serial successive-approximation (binary-search) engine that drives the candidate operand of an external magnitude comparator and consumes its lt/gt/eq flags.
- Locates an unknown N-bit target that is wired to the comparator's other operand.
- Sits on the initiator side of the comparator interface: it produces operands, the comparator answers.
- Used for threshold search, DAC/ADC successive approximation and self-test of comparator instances.

Parameters:
N, 4, operand width in bits; search range 0 .. 2^N-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  begin a search; sampled only in IDLE
cmp_lt  input  1  comparator flag: guess < target
cmp_gt  input  1  comparator flag: guess > target
cmp_eq  input  1  comparator flag: guess == target
guess  output  N  registered candidate driven to the comparator's first operand
busy  output  1  high in SEARCH
done  output  1  one-cycle pulse when a search ends
found  output  1  target located; valid from done, held until next start
result  output  N  located value; valid when found=1, held until next start
steps  output  $clog2(N+2)  compare cycles used by the last search
err  output  1  illegal flag combination aborted the search (see Optional Feature)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset value of every output is 0: guess, busy, done, found, result, steps, err. FSM resets to IDLE. Internal lo/hi are N+1 bits wide and reset to 0.
- The comparator is combinational. Flags must reflect the current `guess` in the same cycle.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - On start=1: lo=0, hi=2^N-1, guess=(2^N-1)>>1, steps=0; clear found, result and err; go to SEARCH.
  - start=0: remain in IDLE.
- SEARCH:
  - busy=1. Each cycle, sample the flags and increment steps.
  - eq: result=guess, found=1, go to DONE.
  - lt: lo=guess+1.
  - gt: hi=guess-1. Computed in N+1 bits; guess=0 gives -1, which is treated as lo>hi.
  - After an lt or gt update:
    - If new lo>hi: found=0, go to DONE.
    - Otherwise guess=floor((lo+hi)/2), computed in N+1 bits and truncated to N, and stay in SEARCH.
- DONE: done=1 for exactly one cycle, busy=0, guess holds; go to IDLE.
- Latency:
  - start is sampled at edge k; the first compare happens in cycle k+1.
  - A search takes at most N+1 compare cycles, and done is asserted in the cycle after the deciding compare.
  - Maximum start-to-done latency is N+2 cycles.
- start during SEARCH or DONE is ignored.
- start=1 on the same cycle that DONE returns to IDLE is not seen; start is sampled only while in IDLE.
- rst in any state takes effect at the next edge: IDLE, all outputs 0. An in-flight search is lost.
- Flags that change while in IDLE or DONE are ignored.

Optional Feature:
- Macro: SAR_FLAG_CHECK_EN.
- Defined:
  - In SEARCH, a flag vector that is not one-hot (all zero, or more than one set) aborts the search: err=1, found=0, go to DONE.
  - err holds until the next start or rst. steps counts the aborting cycle.
- Undefined:
  - Flags are decoded by priority eq > lt > gt. All-zero is treated as gt.
  - err is tied to 0.

Test Plan:
- N=4, target 11: start -> guesses 7(lt), 11(eq); done in cycle 3 after start; found=1, result=11, steps=2.
- N=4, target 0: guesses 7, 3, 1, 0 -> found=1, result=0, steps=4. Covers the gt path down to the bottom boundary.
- N=4, target 15: guesses 7, 11, 13, 14, 15 -> found=1, result=15, steps=5=N+1. Covers the top boundary with no overflow.
- N=4, comparator forced lt always: guesses 7, 11, 13, 14, 15, then lo=16>hi -> found=0, done=1, steps=5, err=0.
  - Also drive start during busy: ignored, the search is unaffected.
- N=4, target 11, rst=1 asserted in the second SEARCH cycle: next edge gives IDLE and all outputs 0. A following start runs a clean search with result 11.
- SAR_FLAG_CHECK_EN defined: cmp_lt=cmp_gt=1 on the first compare -> err=1, found=0, done after 1 step.
  - Undefined: the same stimulus is decoded as lt and the search continues, err=0.

Source files
------------

// File: rtl/sar_search.sv
// sar_search: bit-serial successive-approximation (binary-search) engine.
// Drives the candidate operand of an external combinational magnitude
// comparator and narrows an inclusive [lo, hi] window from its lt/gt/eq
// flags until the target is hit or the window empties.
//
// Optional feature macro: SAR_FLAG_CHECK_EN
//   defined   - a non-one-hot flag vector in SEARCH aborts with err=1
//   undefined - flags decoded eq > lt > gt (all-zero counts as gt), err=0
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   begin a search (sampled only in IDLE)
//   cmp_lt  comparator flag: guess < target
//   cmp_gt  comparator flag: guess > target
//   cmp_eq  comparator flag: guess == target
//   guess   registered candidate to the comparator
//   busy    high while searching
//   done    one-cycle pulse when a search ends
//   found   target located (held until next start)
//   result  located value (held until next start)
//   steps   compare cycles used by the last search
//   err     illegal flag combination aborted the search
module sar_search #(
  parameter int unsigned N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cmp_lt,
  input  logic                   cmp_gt,
  input  logic                   cmp_eq,
  output logic [N-1:0]           guess,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [N-1:0]           result,
  output logic [$clog2(N+2)-1:0] steps,
  output logic                   err
);

  localparam int unsigned SW = $clog2(N + 2);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e          state_q, state_d;
  logic [N:0]      lo_q, lo_d, hi_q, hi_d;
  logic [N-1:0]    guess_q, guess_d, result_q, result_d;
  logic [SW-1:0]   steps_q, steps_d;
  logic            busy_q, busy_d, done_q, done_d, found_q, found_d, err_q, err_d;

  logic            flag_bad, is_lt;
  logic [N:0]      lo_n, hi_n, mid_sum;

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    steps_d  = steps_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    err_d    = err_q;
    lo_n     = lo_q;
    hi_n     = hi_q;
    mid_sum  = '0;
`ifdef SAR_FLAG_CHECK_EN
    flag_bad = !$onehot({cmp_eq, cmp_lt, cmp_gt});
`else
    flag_bad = 1'b0;
`endif
    // Anything that is neither eq nor lt (including all-zero) narrows from above.
    is_lt    = !cmp_eq && cmp_lt;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = {1'b0, {N{1'b1}}};
          guess_d  = {1'b0, {(N-1){1'b1}}};
          steps_d  = '0;
          found_d  = 1'b0;
          result_d = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = StSearch;
        end
      end
      StSearch: begin
        steps_d = steps_q + SW'(1);
        if (flag_bad) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (cmp_eq) begin
          result_d = guess_q;
          found_d  = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = StDone;
        end else begin
          if (is_lt) lo_n = {1'b0, guess_q} + (N+1)'(1);
          else       hi_n = {1'b0, guess_q} - (N+1)'(1);
          lo_d = lo_n;
          hi_d = hi_n;
          // hi_n[N] set means guess was 0 and hi wrapped to -1: window empty.
          if (hi_n[N] || (lo_n > hi_n)) begin
            found_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            // lo, hi <= 2^N-1 here, so the sum fits in N+1 bits.
            mid_sum = lo_n + hi_n;
            guess_d = mid_sum[N:1];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign result = result_q;
  assign steps  = steps_q;
`ifdef SAR_FLAG_CHECK_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search (N=4): table-driven directed searches,
// hand-written reset/abort sequences and randomized targets checked against
// an integer binary-search reference model.
module tb_sar_search;

  localparam int N  = 4;
  localparam int SW = $clog2(N + 2);

  logic          clk = 1'b0;
  logic          rst, start, cmp_lt, cmp_gt, cmp_eq;
  logic [N-1:0]  guess, result;
  logic          busy, done, found, err;
  logic [SW-1:0] steps;

  int checks   = 0;
  int failures = 0;

  int obs_q[$];
  int exp_q[$];

  always #5 clk = ~clk;

  sar_search #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_lt (cmp_lt),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .result (result),
    .steps  (steps),
    .err    (err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Plain integer binary search over [0, 2^N-1]; force_lt models a comparator
  // that always answers "guess < target".
  function automatic void ref_model(input int tgt, input bit force_lt,
                                    output int st, output int fnd, output int res);
    int lo = 0;
    int hi = (1 << N) - 1;
    int g;
    exp_q.delete();
    st = 0; fnd = 0; res = 0;
    while (lo <= hi) begin
      g = (lo + hi) / 2;
      exp_q.push_back(g);
      st++;
      if (!force_lt && g == tgt) begin
        fnd = 1; res = g;
        break;
      end
      if (force_lt || g < tgt) lo = g + 1;
      else                     hi = g - 1;
    end
  endfunction

  // mode 0: honest comparator, 1: always lt, 2: lt&gt on first compare then honest.
  task automatic run_search(input int tgt, input int mode, input bit start_mid,
                            output int o_steps, output int o_found, output int o_result,
                            output int o_err, output int o_lat, output int o_guess);
    obs_q.delete();
    o_lat = -1; o_steps = -1; o_found = -1; o_result = -1; o_err = -1; o_guess = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= N + 4; cyc++) begin
      if (done) begin
        o_lat = cyc; o_steps = int'(steps); o_found = int'(found);
        o_result = int'(result); o_err = int'(err); o_guess = int'(guess);
        break;
      end
      if (busy) begin
        obs_q.push_back(int'(guess));
        if (mode == 1) begin
          cmp_lt = 1'b1; cmp_gt = 1'b0; cmp_eq = 1'b0;
        end else if (mode == 2 && cyc == 1) begin
          cmp_lt = 1'b1; cmp_gt = 1'b1; cmp_eq = 1'b0;
        end else begin
          cmp_lt = (int'(guess) < tgt);
          cmp_gt = (int'(guess) > tgt);
          cmp_eq = (int'(guess) == tgt);
        end
        start = start_mid && (cyc == 2);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (o_lat < 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  typedef struct {
    int tgt; int mode; bit start_mid;
    int steps; int found; int result; int err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int st, fnd, res, er, lat, lg, m_st, m_fnd, m_res;

    rst = 1'b1; start = 1'b0; cmp_lt = 1'b0; cmp_gt = 1'b0; cmp_eq = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", int'({guess, busy, done, found, result, steps, err}), 0);
    rst = 1'b0;
    // Flags in IDLE must be ignored.
    cmp_eq = 1'b1; cmp_lt = 1'b1;
    @(negedge clk);
    check("idle_flags_ignored", int'({guess, busy, done, found}), 0);

    tbl[0] = '{tgt: 11, mode: 0, start_mid: 1'b0, steps: 2, found: 1, result: 11, err: 0};
    tbl[1] = '{tgt: 0,  mode: 0, start_mid: 1'b0, steps: 4, found: 1, result: 0,  err: 0};
    tbl[2] = '{tgt: 15, mode: 0, start_mid: 1'b0, steps: 5, found: 1, result: 15, err: 0};
    tbl[3] = '{tgt: 5,  mode: 1, start_mid: 1'b1, steps: 5, found: 0, result: 0,  err: 0};
`ifdef SAR_FLAG_CHECK_EN
    tbl[4] = '{tgt: 3,  mode: 2, start_mid: 1'b0, steps: 1, found: 0, result: 0,  err: 1};
`else
    // Decoded as lt: window 8..15 then gt down to 8 and empties.
    tbl[4] = '{tgt: 3,  mode: 2, start_mid: 1'b0, steps: 4, found: 0, result: 0,  err: 0};
`endif

    for (int i = 0; i < 5; i++) begin
      run_search(tbl[i].tgt, tbl[i].mode, tbl[i].start_mid, st, fnd, res, er, lat, lg);
      check($sformatf("tbl%0d_steps", i),   st,  tbl[i].steps);
      check($sformatf("tbl%0d_found", i),   fnd, tbl[i].found);
      check($sformatf("tbl%0d_result", i),  res, tbl[i].result);
      check($sformatf("tbl%0d_err", i),     er,  tbl[i].err);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].steps + 1);
      if (obs_q.size() > 0)
        check($sformatf("tbl%0d_guess_hold", i), lg, obs_q[obs_q.size()-1]);
      if (tbl[i].mode != 2) begin
        ref_model(tbl[i].tgt, tbl[i].mode == 1, m_st, m_fnd, m_res);
        check($sformatf("tbl%0d_model_steps", i), m_st, tbl[i].steps);
        check($sformatf("tbl%0d_nguess", i), obs_q.size(), exp_q.size());
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
          check($sformatf("tbl%0d_guess%0d", i, k), obs_q[k], exp_q[k]);
      end
      check_pulse_end($sformatf("tbl%0d", i));
    end

    // Reset during the second SEARCH cycle loses the search.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmp_lt = (int'(guess) < 11); cmp_gt = (int'(guess) > 11); cmp_eq = (int'(guess) == 11);
    @(negedge clk);
    cmp_lt = 1'b0; cmp_gt = 1'b0; cmp_eq = (int'(guess) == 11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_outputs", int'({guess, busy, done, found, result, steps, err}), 0);
    @(negedge clk);
    check("rst_mid_stays_idle", int'({busy, done}), 0);
    run_search(11, 0, 1'b0, st, fnd, res, er, lat, lg);
    check("post_rst_found", fnd, 1);
    check("post_rst_result", res, 11);
    check("post_rst_steps", st, 2);
    check_pulse_end("post_rst");

    // Randomized targets against the reference model.
    for (int i = 0; i < 20; i++) begin
      int t;
      t = int'($urandom_range(0, (1 << N) - 1));
      cmp_lt = 1'($urandom); cmp_gt = 1'($urandom); cmp_eq = 1'($urandom);
      ref_model(t, 1'b0, m_st, m_fnd, m_res);
      run_search(t, 0, 1'b0, st, fnd, res, er, lat, lg);
      check($sformatf("rnd%0d_t%0d_steps", i, t),  st,  m_st);
      check($sformatf("rnd%0d_t%0d_found", i, t),  fnd, m_fnd);
      check($sformatf("rnd%0d_t%0d_result", i, t), res, m_res);
      check($sformatf("rnd%0d_t%0d_err", i, t),    er,  0);
      check($sformatf("rnd%0d_t%0d_nguess", i, t), obs_q.size(), exp_q.size());
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
        check($sformatf("rnd%0d_guess%0d", i, k), obs_q[k], exp_q[k]);
      check_pulse_end($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
